// File: rtl/frog_pkg.sv
// Shared encodings and helpers for the two-player frog round sequencer.
package frog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

  function automatic logic [3:0] therm(input logic [1:0] lives);
    case (lives)
      2'd0:    therm = 4'b0000;
      2'd1:    therm = 4'b0001;
      2'd2:    therm = 4'b0011;
      2'd3:    therm = 4'b0111;
      default: therm = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/frog_life_tracker.sv
// Per-player hit edge detect, lives counter, post-respawn grace window and respawn pulse.
module frog_life_tracker
  import frog_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int GRACE_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       tick,
  input  logic       spawn,
  input  logic       hit,
  output logic [1:0] lives_q,
  output logic [1:0] lives_d,
  output logic       respawn_q
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] GRACE_INIT = 8'(GRACE_TICKS);

  logic       hit_prev_q;
  logic [7:0] grace_q;
  logic [7:0] grace_d;
  logic       lose_s;
  logic       respawn_d;

  // Next-state for lives and grace; a life is only lost on a fresh hit outside grace.
  always_comb begin
    lose_s    = en && hit && !hit_prev_q && (grace_q == 8'd0) && (lives_q != 2'd0);
    lives_d   = lives_q;
    grace_d   = grace_q;
    respawn_d = spawn || lose_s;
    if (clr) begin
      lives_d = LIVES_INIT;
      grace_d = 8'd0;
    end else if (lose_s) begin
      lives_d = lives_q - 2'd1;
      grace_d = GRACE_INIT;
    end else if (tick && (grace_q != 8'd0)) begin
      grace_d = grace_q - 8'd1;
    end else begin
      grace_d = grace_q;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_prev_q <= 1'b0;
      lives_q    <= LIVES_INIT;
      grace_q    <= 8'd0;
      respawn_q  <= 1'b0;
    end else begin
      hit_prev_q <= hit;
      lives_q    <= lives_d;
      grace_q    <= grace_d;
      respawn_q  <= respawn_d;
    end
  end

endmodule

// File: rtl/frog_round_ctrl.sv
// Round sequencer for the two-player frog game: countdown, play, timeout and result lights.
module frog_round_ctrl
  import frog_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int READY_SECS  = 3,
  parameter int ROUND_SECS  = 60,
  parameter int GRACE_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       hit_1,
  input  logic       hit_2,
  input  logic       goal_1,
  input  logic       goal_2,
  output logic       freeze,
  output logic       respawn_1,
  output logic       respawn_2,
  output logic [3:0] light_1,
  output logic [3:0] light_2,
  output logic [1:0] winner,
  output logic [6:0] time_left,
  output logic [1:0] state
);

  localparam logic [3:0] READY_INIT = 4'(READY_SECS);
  localparam logic [6:0] ROUND_INIT = 7'(ROUND_SECS);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] time_left_q, time_left_d;
  logic [3:0] light_1_q, light_1_d, light_2_q, light_2_d;
  logic       freeze_q, freeze_d;
  logic       start_prev_q;
  logic       start_edge_s, clr_s, spawn_s, en_s, ko_1_s, ko_2_s;
  logic [1:0] lives_1_q, lives_1_d, lives_2_q, lives_2_d;

  frog_life_tracker #(.LIVES(LIVES), .GRACE_TICKS(GRACE_TICKS)) u_life_1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .en(en_s), .tick(tick), .spawn(spawn_s),
    .hit(hit_1), .lives_q(lives_1_q), .lives_d(lives_1_d), .respawn_q(respawn_1)
  );

  frog_life_tracker #(.LIVES(LIVES), .GRACE_TICKS(GRACE_TICKS)) u_life_2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .en(en_s), .tick(tick), .spawn(spawn_s),
    .hit(hit_2), .lives_q(lives_2_q), .lives_d(lives_2_d), .respawn_q(respawn_2)
  );

  // Round FSM next-state; goals beat hits, knockout beats timeout.
  always_comb begin
    start_edge_s = start && !start_prev_q;
    state_d      = state_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    time_left_d  = time_left_q;
    clr_s        = 1'b0;
    spawn_s      = 1'b0;
    en_s         = 1'b0;
    ko_1_s       = 1'b0;
    ko_2_s       = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_edge_s) begin
          state_d     = READY;
          winner_d    = W_NONE;
          cnt_d       = READY_INIT;
          time_left_d = ROUND_INIT;
          clr_s       = 1'b1;
          spawn_s     = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      READY: begin
        if (tick && (cnt_q == 4'd1)) begin
          state_d     = PLAY;
          time_left_d = ROUND_INIT;
        end else if (tick) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      PLAY: begin
        if (goal_1 || goal_2) begin
          state_d = OVER;
          if (goal_1 && goal_2) begin
            winner_d = W_DRAW;
          end else if (goal_1) begin
            winner_d = W_P1;
          end else begin
            winner_d = W_P2;
          end
        end else begin
          en_s   = 1'b1;
          ko_1_s = (lives_1_d == 2'd0);
          ko_2_s = (lives_2_d == 2'd0);
          if (tick) begin
            time_left_d = time_left_q - 7'd1;
          end else begin
            time_left_d = time_left_q;
          end
          if (ko_1_s || ko_2_s) begin
            state_d = OVER;
            if (ko_1_s && ko_2_s) begin
              winner_d = W_DRAW;
            end else if (ko_1_s) begin
              winner_d = W_P2;
            end else begin
              winner_d = W_P1;
            end
          end else if (tick && (time_left_q == 7'd1)) begin
            state_d = OVER;
            if (lives_1_d > lives_2_d) begin
              winner_d = W_P1;
            end else if (lives_2_d > lives_1_d) begin
              winner_d = W_P2;
            end else begin
              winner_d = W_DRAW;
            end
          end else begin
            state_d = PLAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lights and freeze follow the next state so they register alongside it.
  always_comb begin
    freeze_d  = (state_d != PLAY);
    light_1_d = therm(lives_1_d);
    light_2_d = therm(lives_2_d);
    if (state_d == OVER) begin
      case (winner_d)
        W_P1: begin
          light_1_d = 4'b1111;
          light_2_d = 4'b0000;
        end
        W_P2: begin
          light_1_d = 4'b0000;
          light_2_d = 4'b1111;
        end
        default: begin
          light_1_d = therm(lives_1_d);
          light_2_d = therm(lives_2_d);
        end
      endcase
    end else begin
      light_1_d = therm(lives_1_d);
      light_2_d = therm(lives_2_d);
    end
  end

  // Round state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      winner_q     <= W_NONE;
      cnt_q        <= READY_INIT;
      time_left_q  <= ROUND_INIT;
      light_1_q    <= therm(LIVES_INIT);
      light_2_q    <= therm(LIVES_INIT);
      freeze_q     <= 1'b1;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      time_left_q  <= time_left_d;
      light_1_q    <= light_1_d;
      light_2_q    <= light_2_d;
      freeze_q     <= freeze_d;
      start_prev_q <= start;
    end
  end

  assign state     = state_q;
  assign winner    = winner_q;
  assign time_left = time_left_q;
  assign light_1   = light_1_q;
  assign light_2   = light_2_q;
  assign freeze    = freeze_q;

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Scoreboard bench for frog_round_ctrl: expectations queued with stimulus, drained at sample time.
module tb_frog_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick, start, hit_1, hit_2, goal_1, goal_2;
  logic       freeze, respawn_1, respawn_2;
  logic [3:0] light_1, light_2;
  logic [1:0] winner, state;
  logic [6:0] time_left;

  int n_tests = 0;
  int n_fail  = 0;
  int rsp1_n  = 0;
  int rsp2_n  = 0;

  localparam int S_STATE = 0, S_FREEZE = 1, S_L1 = 2, S_L2 = 3, S_WIN = 4,
                 S_TL = 5, S_RSP1 = 6, S_RSP2 = 7;

  typedef struct {
    string tag;
    int    sig;
    int    exp;
  } exp_t;

  exp_t sb_q[$];

  frog_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .hit_1(hit_1), .hit_2(hit_2), .goal_1(goal_1), .goal_2(goal_2),
    .freeze(freeze), .respawn_1(respawn_1), .respawn_2(respawn_2),
    .light_1(light_1), .light_2(light_2), .winner(winner),
    .time_left(time_left), .state(state)
  );

  always #5 clk = ~clk;

  // Count respawn pulses mid-cycle.
  always @(negedge clk) begin
    rsp1_n <= rsp1_n + (respawn_1 ? 1 : 0);
    rsp2_n <= rsp2_n + (respawn_2 ? 1 : 0);
  end

  function automatic int observe(input int sig);
    case (sig)
      S_STATE:  return int'(state);
      S_FREEZE: return int'(freeze);
      S_L1:     return int'(light_1);
      S_L2:     return int'(light_2);
      S_WIN:    return int'(winner);
      S_TL:     return int'(time_left);
      S_RSP1:   return rsp1_n;
      S_RSP2:   return rsp2_n;
      default:  return -1;
    endcase
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sig, input int exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain;
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  task automatic pulse_hit(input int p);
    if (p == 1) hit_1 = 1'b1; else hit_2 = 1'b1;
    step(1);
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    step(1);
  endtask

  task automatic expect_over(input string tag, input int win, input int l1, input int l2);
    push_exp({tag, "_state"}, S_STATE, 3);
    push_exp({tag, "_win"}, S_WIN, win);
    push_exp({tag, "_l1"}, S_L1, l1);
    push_exp({tag, "_l2"}, S_L2, l2);
    push_exp({tag, "_freeze"}, S_FREEZE, 1);
  endtask

  task automatic enter_play(input int r1, input int r2);
    pulse_start();
    push_exp("ready_state", S_STATE, 1);
    push_exp("ready_win", S_WIN, 0);
    push_exp("ready_l1", S_L1, 4'b0111);
    push_exp("ready_l2", S_L2, 4'b0111);
    drain();
    ticks(2);
    push_exp("still_ready", S_STATE, 1);
    drain();
    ticks(1);
    push_exp("play_state", S_STATE, 2);
    push_exp("play_freeze", S_FREEZE, 0);
    push_exp("play_tl", S_TL, 60);
    push_exp("play_rsp1", S_RSP1, r1);
    push_exp("play_rsp2", S_RSP2, r2);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0;
    hit_1 = 1'b0; hit_2 = 1'b0; goal_1 = 1'b0; goal_2 = 1'b0;
    step(3);
    push_exp("rst_state", S_STATE, 0);
    push_exp("rst_freeze", S_FREEZE, 1);
    push_exp("rst_l1", S_L1, 4'b0111);
    push_exp("rst_l2", S_L2, 4'b0111);
    push_exp("rst_win", S_WIN, 0);
    push_exp("rst_tl", S_TL, 60);
    drain();
    rst_n = 1'b1;
    step(2);

    // Countdown and first hit with grace.
    enter_play(1, 1);
    hit_1 = 1'b1;
    step(10);
    hit_1 = 1'b0;
    step(1);
    push_exp("hold_l1", S_L1, 4'b0011);
    push_exp("hold_rsp1", S_RSP1, 2);
    drain();
    pulse_hit(1);
    push_exp("grace_l1", S_L1, 4'b0011);
    push_exp("grace_rsp1", S_RSP1, 2);
    drain();
    ticks(1);
    pulse_hit(1);
    push_exp("after_tick_l1", S_L1, 4'b0001);
    push_exp("after_tick_rsp1", S_RSP1, 3);
    push_exp("after_tick_tl", S_TL, 59);
    drain();

    // Player 2 knocked out.
    for (int k = 0; k < 3; k++) begin
      pulse_hit(2);
      ticks(1);
    end
    expect_over("ko", 1, 4'b1111, 4'b0000);
    push_exp("ko_tl", S_TL, 57);
    push_exp("ko_rsp2", S_RSP2, 4);
    drain();

    // Simultaneous goals with a hit edge.
    enter_play(4, 5);
    goal_1 = 1'b1; goal_2 = 1'b1; hit_1 = 1'b1;
    step(1);
    goal_1 = 1'b0; goal_2 = 1'b0; hit_1 = 1'b0;
    step(1);
    expect_over("goals", 3, 4'b0111, 4'b0111);
    push_exp("goals_rsp1", S_RSP1, 4);
    drain();

    // Timeout, player 2 ahead on lives.
    enter_play(5, 6);
    pulse_hit(1);
    ticks(59);
    push_exp("tl_one", S_TL, 1);
    push_exp("tl_one_state", S_STATE, 2);
    drain();
    ticks(1);
    expect_over("timeout", 2, 4'b0000, 4'b1111);
    push_exp("timeout_tl", S_TL, 0);
    drain();

    // Timeout with equal lives.
    enter_play(7, 7);
    ticks(60);
    expect_over("tdraw", 3, 4'b0111, 4'b0111);
    push_exp("tdraw_tl", S_TL, 0);
    drain();

    // Asynchronous reset mid-play.
    enter_play(8, 8);
    pulse_hit(1);
    ticks(5);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("arst_state", S_STATE, 0);
    push_exp("arst_freeze", S_FREEZE, 1);
    push_exp("arst_l1", S_L1, 4'b0111);
    push_exp("arst_win", S_WIN, 0);
    push_exp("arst_tl", S_TL, 60);
    drain();
    step(2);
    push_exp("arst_rsp1", S_RSP1, 9);
    push_exp("arst_rsp2", S_RSP2, 8);
    drain();
    rst_n = 1'b1;
    step(1);

    // Restart from OVER after a single-goal win.
    enter_play(10, 9);
    goal_1 = 1'b1;
    step(1);
    goal_1 = 1'b0;
    step(1);
    expect_over("goal1", 1, 4'b1111, 4'b0000);
    drain();
    pulse_start();
    push_exp("restart_state", S_STATE, 1);
    push_exp("restart_win", S_WIN, 0);
    push_exp("restart_l1", S_L1, 4'b0111);
    push_exp("restart_l2", S_L2, 4'b0111);
    push_exp("restart_rsp1", S_RSP1, 11);
    push_exp("restart_rsp2", S_RSP2, 10);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
